// File: rtl/ix_sched.sv
// ix_sched: in-order issue gate between decode and execute.
// Tracks pending long-latency writebacks in a 32-bit scoreboard, limits the
// number of outstanding long ops, serialises use of the single mul/div unit
// and counts RAW and structural stall cycles. DEC -> EX is zero-latency.
module ix_sched #(
    parameter int LT_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_flush,
    input  logic        dec_ix_valid,
    output logic        dec_ix_ready,
    input  logic [4:0]  dec_ix_rs1,
    input  logic [4:0]  dec_ix_rs2,
    input  logic [4:0]  dec_ix_rd,
    input  logic        dec_ix_use_rs1,
    input  logic        dec_ix_use_rs2,
    input  logic        dec_ix_wb_en,
    input  logic        dec_ix_long,
    input  logic        dec_ix_muldiv,
    output logic        ix_ex_valid,
    input  logic        ix_ex_ready,
    input  logic        lt_wb_valid,
    input  logic [4:0]  lt_wb_rd,
    input  logic        md_done,
    output logic [31:0] sb_pending,
    output logic [31:0] stall_raw_cnt,
    output logic [31:0] stall_struct_cnt
);

    logic [31:0] sb_reg, sb_next;
    logic [2:0]  lt_cnt_reg, lt_cnt_next;
    logic        md_busy_reg, md_busy_next;
    logic [31:0] raw_cnt_reg, raw_cnt_next;
    logic [31:0] struct_cnt_reg, struct_cnt_next;

    logic [31:0] hit_vec;
    logic        lt_dec;
    logic [2:0]  lt_cnt_eff;
    logic        raw_stall;
    logic        struct_stall;
    logic        issue;
    logic        lt_inc;

    // A register is a hazard only while its long op has not yet written back;
    // a writeback in this very cycle bypasses, and x0 never hazards.
    assign hit_vec[0] = 1'b0;
    for (genvar gi = 1; gi < 32; gi++) begin : g_hit
        assign hit_vec[gi] = sb_reg[gi] && !(lt_wb_valid && (lt_wb_rd == 5'(gi)));
    end

    // A writeback arriving with nothing outstanding is dropped so the count
    // cannot wrap below zero.
    assign lt_dec     = lt_wb_valid && (lt_cnt_reg != 3'd0);
    assign lt_cnt_eff = lt_cnt_reg - {2'b00, lt_dec};

    // Destination is checked too so a younger write cannot overtake an
    // older pending long write (WAW).
    assign raw_stall = (dec_ix_use_rs1 && hit_vec[dec_ix_rs1])
                    || (dec_ix_use_rs2 && hit_vec[dec_ix_rs2])
                    || (dec_ix_wb_en   && hit_vec[dec_ix_rd]);

    assign struct_stall = (dec_ix_long && (lt_cnt_eff == 3'(LT_MAX)))
                       || (dec_ix_muldiv && md_busy_reg && !md_done);

    assign ix_ex_valid  = dec_ix_valid && !raw_stall && !struct_stall && !pipe_flush;
    // Flush is deliberately absent here: a flushed instruction is consumed.
    assign dec_ix_ready = ix_ex_ready && !(dec_ix_valid && (raw_stall || struct_stall));
    assign issue        = ix_ex_valid && ix_ex_ready;
    assign lt_inc       = issue && dec_ix_long;

    assign sb_pending       = sb_reg;
    assign stall_raw_cnt    = raw_cnt_reg;
    assign stall_struct_cnt = struct_cnt_reg;

    // Next-state for scoreboard, long-op count, mul/div busy and counters.
    always_comb begin
        sb_next         = sb_reg;
        lt_cnt_next     = lt_cnt_reg;
        md_busy_next    = md_busy_reg;
        raw_cnt_next    = raw_cnt_reg;
        struct_cnt_next = struct_cnt_reg;

        // Clear first so a same-cycle set of the same register wins.
        if (lt_wb_valid) begin
            sb_next[lt_wb_rd] = 1'b0;
        end
        if (issue && dec_ix_long && dec_ix_wb_en && (dec_ix_rd != 5'd0)) begin
            sb_next[dec_ix_rd] = 1'b1;
        end
        sb_next[0] = 1'b0;

        if (lt_inc && !lt_dec) begin
            lt_cnt_next = lt_cnt_reg + 3'd1;
        end else if (lt_dec && !lt_inc) begin
            lt_cnt_next = lt_cnt_reg - 3'd1;
        end

        if (issue && dec_ix_muldiv) begin
            md_busy_next = 1'b1;
        end else if (md_done) begin
            md_busy_next = 1'b0;
        end

        if (dec_ix_valid && !pipe_flush) begin
            if (raw_stall) begin
                raw_cnt_next = raw_cnt_reg + 32'd1;
            end else if (struct_stall) begin
                struct_cnt_next = struct_cnt_reg + 32'd1;
            end
        end
    end

    // State registers; reset overrides every same-cycle event.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_reg         <= '0;
            lt_cnt_reg     <= '0;
            md_busy_reg    <= 1'b0;
            raw_cnt_reg    <= '0;
            struct_cnt_reg <= '0;
        end else begin
            sb_reg         <= sb_next;
            lt_cnt_reg     <= lt_cnt_next;
            md_busy_reg    <= md_busy_next;
            raw_cnt_reg    <= raw_cnt_next;
            struct_cnt_reg <= struct_cnt_next;
        end
    end

endmodule

// File: tb/tb_ix_sched.sv
// Directed bench for ix_sched: expected values are queued as each stimulus
// step is driven and popped when the corresponding output is sampled.
module tb_ix_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_flush = 1'b0;
    logic        dec_ix_valid = 1'b0;
    logic        dec_ix_ready;
    logic [4:0]  dec_ix_rs1 = '0;
    logic [4:0]  dec_ix_rs2 = '0;
    logic [4:0]  dec_ix_rd = '0;
    logic        dec_ix_use_rs1 = 1'b0;
    logic        dec_ix_use_rs2 = 1'b0;
    logic        dec_ix_wb_en = 1'b0;
    logic        dec_ix_long = 1'b0;
    logic        dec_ix_muldiv = 1'b0;
    logic        ix_ex_valid;
    logic        ix_ex_ready = 1'b0;
    logic        lt_wb_valid = 1'b0;
    logic [4:0]  lt_wb_rd = '0;
    logic        md_done = 1'b0;
    logic [31:0] sb_pending;
    logic [31:0] stall_raw_cnt;
    logic [31:0] stall_struct_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    ix_sched #(.LT_MAX(3)) dut (
        .clk              (clk),
        .rst              (rst),
        .pipe_flush       (pipe_flush),
        .dec_ix_valid     (dec_ix_valid),
        .dec_ix_ready     (dec_ix_ready),
        .dec_ix_rs1       (dec_ix_rs1),
        .dec_ix_rs2       (dec_ix_rs2),
        .dec_ix_rd        (dec_ix_rd),
        .dec_ix_use_rs1   (dec_ix_use_rs1),
        .dec_ix_use_rs2   (dec_ix_use_rs2),
        .dec_ix_wb_en     (dec_ix_wb_en),
        .dec_ix_long      (dec_ix_long),
        .dec_ix_muldiv    (dec_ix_muldiv),
        .ix_ex_valid      (ix_ex_valid),
        .ix_ex_ready      (ix_ex_ready),
        .lt_wb_valid      (lt_wb_valid),
        .lt_wb_rd         (lt_wb_rd),
        .md_done          (md_done),
        .sb_pending       (sb_pending),
        .stall_raw_cnt    (stall_raw_cnt),
        .stall_struct_cnt (stall_struct_cnt)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s observed %h expected <none queued>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            $display("check %-18s observed %h expected %h", tag, obs, e);
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic dec(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rd, input logic wb, input logic lg,
                       input logic md);
        dec_ix_valid   = v;
        dec_ix_rs1     = rs1;
        dec_ix_use_rs1 = u1;
        dec_ix_rs2     = 5'd0;
        dec_ix_use_rs2 = 1'b0;
        dec_ix_rd      = rd;
        dec_ix_wb_en   = wb;
        dec_ix_long    = lg;
        dec_ix_muldiv  = md;
    endtask

    task automatic wbk(input logic v, input logic [4:0] rd);
        lt_wb_valid = v;
        lt_wb_rd    = rd;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- reset, with a long issue in flight during reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        ix_ex_ready = 1'b1;
        dec(1, 0, 0, 5, 1, 1, 0);
        push(32'h0); push(32'h0); push(32'h0);
        edge_wait();
        pop_chk("rst_sb", sb_pending);
        pop_chk("rst_raw_cnt", stall_raw_cnt);
        pop_chk("rst_struct_cnt", stall_struct_cnt);

        @(negedge clk);
        rst = 1'b0;
        ix_ex_ready = 1'b0;
        dec(1, 0, 0, 0, 0, 0, 0);
        push(32'h1); push(32'h0);
        #1;
        pop_chk("rst_valid_pass", {31'h0, ix_ex_valid});
        pop_chk("rst_ready_pass", {31'h0, dec_ix_ready});

        // ---- RAW on a pending load, resolved by same-cycle writeback
        @(negedge clk);
        ix_ex_ready = 1'b1;
        dec(1, 0, 0, 5, 1, 1, 0);
        push(32'h1);
        #1 pop_chk("raw_load_issue", {31'h0, ix_ex_valid});
        push(32'h20);
        edge_wait();
        pop_chk("raw_sb_set", sb_pending);

        @(negedge clk);
        dec(1, 5, 1, 6, 1, 0, 0);
        push(32'h0); push(32'h0);
        #1;
        pop_chk("raw_stall_valid", {31'h0, ix_ex_valid});
        pop_chk("raw_stall_ready", {31'h0, dec_ix_ready});
        push(32'h1);
        edge_wait();
        pop_chk("raw_cnt_1", stall_raw_cnt);
        push(32'h2);
        edge_wait();
        pop_chk("raw_cnt_2", stall_raw_cnt);

        @(negedge clk);
        wbk(1, 5);
        push(32'h1); push(32'h1);
        #1;
        pop_chk("raw_bypass_valid", {31'h0, ix_ex_valid});
        pop_chk("raw_bypass_ready", {31'h0, dec_ix_ready});
        push(32'h0); push(32'h2);
        edge_wait();
        pop_chk("raw_sb_clear", sb_pending);
        pop_chk("raw_cnt_hold", stall_raw_cnt);

        // ---- flush during a RAW stall
        @(negedge clk);
        wbk(0, 0);
        dec(1, 0, 0, 5, 1, 1, 0);
        edge_wait();
        @(negedge clk);
        dec(1, 5, 1, 6, 1, 0, 0);
        pipe_flush = 1'b1;
        push(32'h0);
        #1 pop_chk("flush_valid", {31'h0, ix_ex_valid});
        push(32'h2); push(32'h0); push(32'h20);
        edge_wait();
        pop_chk("flush_raw_frozen", stall_raw_cnt);
        pop_chk("flush_struct_frozen", stall_struct_cnt);
        pop_chk("flush_sb_kept", sb_pending);
        @(negedge clk);
        pipe_flush = 1'b0;
        dec(0, 0, 0, 0, 0, 0, 0);
        wbk(1, 5);
        edge_wait();

        // ---- long-op limit: three loads outstanding, fourth waits
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            wbk(0, 0);
            dec(1, 0, 0, 5'(i), 1, 1, 0);
            edge_wait();
        end
        @(negedge clk);
        dec(1, 0, 0, 7, 1, 1, 0);
        push(32'h0);
        #1 pop_chk("lt_full_stall", {31'h0, ix_ex_valid});
        push(32'h1); push(32'h0000_000E);
        edge_wait();
        pop_chk("lt_struct_cnt_1", stall_struct_cnt);
        pop_chk("lt_sb_three", sb_pending);

        @(negedge clk);
        wbk(1, 1);
        push(32'h1);
        #1 pop_chk("lt_wb_frees_slot", {31'h0, ix_ex_valid});
        push(32'h0000_008C);
        edge_wait();
        pop_chk("lt_sb_swap", sb_pending);

        @(negedge clk);
        wbk(0, 0);
        dec(1, 0, 0, 8, 1, 1, 0);
        push(32'h0);
        #1 pop_chk("lt_cnt_still_full", {31'h0, ix_ex_valid});
        push(32'h2);
        edge_wait();
        pop_chk("lt_struct_cnt_2", stall_struct_cnt);

        @(negedge clk);
        dec(0, 0, 0, 0, 0, 0, 0);
        wbk(1, 2); edge_wait();
        @(negedge clk); wbk(1, 3); edge_wait();
        @(negedge clk); wbk(1, 7); edge_wait();
        // writeback with nothing outstanding must not wrap the count
        @(negedge clk); wbk(1, 9); edge_wait();
        for (int i = 10; i <= 12; i++) begin
            @(negedge clk);
            wbk(0, 0);
            dec(1, 0, 0, 5'(i), 1, 1, 0);
            edge_wait();
        end
        @(negedge clk);
        dec(1, 0, 0, 13, 1, 1, 0);
        push(32'h0);
        #1 pop_chk("lt_no_wrap_stall", {31'h0, ix_ex_valid});
        push(32'h3);
        edge_wait();
        pop_chk("lt_struct_cnt_3", stall_struct_cnt);
        @(negedge clk);
        dec(0, 0, 0, 0, 0, 0, 0);
        wbk(1, 10); edge_wait();
        @(negedge clk); wbk(1, 11); edge_wait();
        @(negedge clk); wbk(1, 12); edge_wait();
        @(negedge clk);
        wbk(0, 0);
        push(32'h0);
        #1 pop_chk("lt_sb_drained", sb_pending);

        // ---- mul/div unit occupancy
        dec(1, 0, 0, 0, 0, 0, 1);
        push(32'h1);
        #1 pop_chk("md_first_issue", {31'h0, ix_ex_valid});
        edge_wait();
        @(negedge clk);
        push(32'h0);
        #1 pop_chk("md_busy_stall", {31'h0, ix_ex_valid});
        push(32'h4);
        edge_wait();
        pop_chk("md_struct_cnt_4", stall_struct_cnt);
        @(negedge clk);
        md_done = 1'b1;
        push(32'h1);
        #1 pop_chk("md_issue_on_done", {31'h0, ix_ex_valid});
        edge_wait();
        @(negedge clk);
        md_done = 1'b0;
        push(32'h0);
        #1 pop_chk("md_busy_kept", {31'h0, ix_ex_valid});
        push(32'h5);
        edge_wait();
        pop_chk("md_struct_cnt_5", stall_struct_cnt);
        @(negedge clk);
        dec(0, 0, 0, 0, 0, 0, 0);
        md_done = 1'b1;
        edge_wait();
        @(negedge clk);
        md_done = 1'b0;

        // ---- x0 never becomes pending
        dec(1, 0, 0, 0, 1, 1, 0);
        push(32'h1);
        #1 pop_chk("x0_load_issue", {31'h0, ix_ex_valid});
        push(32'h0);
        edge_wait();
        pop_chk("x0_sb_empty", sb_pending);
        @(negedge clk);
        dec(1, 0, 1, 0, 1, 0, 0);
        push(32'h1);
        #1 pop_chk("x0_no_stall", {31'h0, ix_ex_valid});
        push(32'h2);
        edge_wait();
        pop_chk("x0_raw_cnt", stall_raw_cnt);

        // ---- reset in the middle of activity
        @(negedge clk);
        dec(1, 0, 0, 5, 1, 1, 0);
        edge_wait();
        @(negedge clk);
        dec(1, 0, 0, 0, 0, 0, 1);
        push(32'h20);
        edge_wait();
        pop_chk("mid_sb_before", sb_pending);
        @(negedge clk);
        rst = 1'b1;
        push(32'h0);
        #1 pop_chk("mid_md_busy_stall", {31'h0, ix_ex_valid});
        push(32'h0); push(32'h0); push(32'h0);
        edge_wait();
        pop_chk("mid_sb_cleared", sb_pending);
        pop_chk("mid_raw_cleared", stall_raw_cnt);
        pop_chk("mid_struct_cleared", stall_struct_cnt);
        @(negedge clk);
        rst = 1'b0;
        push(32'h1);
        #1 pop_chk("mid_md_issue", {31'h0, ix_ex_valid});

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drained observed %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
